counter_dispatcher: RTL

COUNTER_DISPATCHER -- requirements
Module: counter_dispatcher

---
 rtl/counter_dispatcher_pkg.sv | 27 ++
 rtl/rr_arbiter5.sv | 35 +++
 rtl/counter_dispatcher.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/counter_dispatcher_pkg.sv
// Shared definitions for the ticket dispatcher: FSM states, sizes, counter indices
// and the ticket-number wrap helper.
package counter_dispatcher_pkg;

    localparam int NUM_COUNTERS = 5;
    localparam int TICKET_W     = 6;
    localparam int TICKET_MAX   = 63;
    localparam int IDX_W        = 3;

    localparam logic [IDX_W-1:0] CNT_A = 3'd0;
    localparam logic [IDX_W-1:0] CNT_B = 3'd1;
    localparam logic [IDX_W-1:0] CNT_C = 3'd2;
    localparam logic [IDX_W-1:0] CNT_D = 3'd3;
    localparam logic [IDX_W-1:0] CNT_E = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARB      = 2'd1,
        ST_ANNOUNCE = 2'd2
    } state_t;

    // Ticket numbers run 1..TICKET_MAX and skip 0, which means "none".
    function automatic logic [TICKET_W-1:0] next_ticket(input logic [TICKET_W-1:0] t);
        return (t == TICKET_W'(TICKET_MAX)) ? TICKET_W'(1) : t + TICKET_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Combinational round-robin picker over five requesters; the search starts one
// position after the last granted index and wraps around.
module rr_arbiter5
    import counter_dispatcher_pkg::*;
(
    input  logic [NUM_COUNTERS-1:0] i_req,
    input  logic [IDX_W-1:0]        i_last,
    output logic [NUM_COUNTERS-1:0] o_grant,
    output logic [IDX_W-1:0]        o_idx,
    output logic                    o_valid
);

    logic [3:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_COUNTERS; k++) begin
            w_cand = {1'b0, i_last} + 4'(k);
            if (w_cand >= 4'(NUM_COUNTERS)) begin
                w_cand = w_cand - 4'(NUM_COUNTERS);
            end
            if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
        if (o_valid) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/counter_dispatcher.sv
// Ticket dispenser and caller for five service counters: issues numbered tickets on
// button presses, queues them, and announces each to the next free counter in turn.
module counter_dispatcher
    import counter_dispatcher_pkg::*;
#(
    parameter int MAX_WAIT    = 16,
    parameter int CALL_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    button,
    input  logic [NUM_COUNTERS-1:0] counter_done,
    output logic [TICKET_W-1:0]     ticket_number,
    output logic                    ticket_reject,
    output logic [TICKET_W-1:0]     waiting_count,
    output logic [NUM_COUNTERS-1:0] counter_busy,
    output logic                    call_valid,
    output logic [IDX_W-1:0]        counter_call,
    output logic [TICKET_W-1:0]     number_service,
    output logic [TICKET_W-1:0]     A_serviceNumber,
    output logic [TICKET_W-1:0]     B_serviceNumber,
    output logic [TICKET_W-1:0]     C_serviceNumber,
    output logic [TICKET_W-1:0]     D_serviceNumber,
    output logic [TICKET_W-1:0]     E_serviceNumber
);

    localparam int                  HOLD_W     = (CALL_CYCLES > 1) ? $clog2(CALL_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(CALL_CYCLES - 1);
    localparam logic [TICKET_W-1:0] MAX_WAIT_V = TICKET_W'(MAX_WAIT);

    logic                r_button;
    logic [TICKET_W-1:0] r_ticket_number;
    logic [TICKET_W-1:0] r_next_ticket;
    logic                r_reject;
    logic [TICKET_W-1:0] r_waiting;
    logic [TICKET_W-1:0] r_next_call;
    logic                r_busy [NUM_COUNTERS];
    logic [TICKET_W-1:0] r_svc  [NUM_COUNTERS];
    state_t              r_state;
    logic                r_call_valid;
    logic [IDX_W-1:0]    r_counter_call;
    logic [TICKET_W-1:0] r_number_service;
    logic [IDX_W-1:0]    r_last_grant;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic                    w_req_edge;
    logic                    w_issue;
    logic                    w_grant_en;
    logic [NUM_COUNTERS-1:0] w_busy;
    logic [NUM_COUNTERS-1:0] w_arb_grant;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_arb_valid;

    assign w_req_edge = button & ~r_button;
    assign w_issue    = w_req_edge && (r_waiting != MAX_WAIT_V);
    assign w_grant_en = (r_state == ST_ARB) && w_arb_valid;

    rr_arbiter5 u_arbiter (
        .i_req   (~w_busy),
        .i_last  (r_last_grant),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Ticket issue: one ticket per 0->1 step of the sampled button, refused when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_button        <= 1'b0;
            r_ticket_number <= '0;
            r_next_ticket   <= TICKET_W'(1);
            r_reject        <= 1'b0;
        end else begin
            r_button <= button;
            r_reject <= w_req_edge && !w_issue;
            if (w_issue) begin
                r_ticket_number <= r_next_ticket;
                r_next_ticket   <= next_ticket(r_next_ticket);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waiting <= '0;
        end else begin
            case ({w_issue, w_grant_en})
                2'b10:   r_waiting <= r_waiting + TICKET_W'(1);
                2'b01:   r_waiting <= r_waiting - TICKET_W'(1);
                default: r_waiting <= r_waiting;
            endcase
        end
    end

    // A grant only ever targets an idle counter, so it never collides with a done pulse
    // on a busy one; a done pulse on an idle counter just rewrites zeros.
    for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_counter
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_busy[gi] <= 1'b0;
                r_svc[gi]  <= '0;
            end else if (w_grant_en && w_arb_grant[gi]) begin
                r_busy[gi] <= 1'b1;
                r_svc[gi]  <= r_next_call;
            end else if (counter_done[gi]) begin
                r_busy[gi] <= 1'b0;
                r_svc[gi]  <= '0;
            end
        end
        assign w_busy[gi] = r_busy[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_call_valid     <= 1'b0;
            r_counter_call   <= '0;
            r_number_service <= '0;
            r_next_call      <= TICKET_W'(1);
            r_last_grant     <= CNT_E;
            r_hold_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_call_valid <= 1'b0;
                    if ((r_waiting != '0) && w_arb_valid) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (w_arb_valid) begin
                        r_state          <= ST_ANNOUNCE;
                        r_call_valid     <= 1'b1;
                        r_counter_call   <= w_arb_idx;
                        r_number_service <= r_next_call;
                        r_next_call      <= next_ticket(r_next_call);
                        r_last_grant     <= w_arb_idx;
                        r_hold_cnt       <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ANNOUNCE: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state      <= ST_IDLE;
                        r_call_valid <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_call_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ticket_number   = r_ticket_number;
    assign ticket_reject   = r_reject;
    assign waiting_count   = r_waiting;
    assign counter_busy    = w_busy;
    assign call_valid      = r_call_valid;
    assign counter_call    = r_counter_call;
    assign number_service  = r_number_service;
    assign A_serviceNumber = r_svc[CNT_A];
    assign B_serviceNumber = r_svc[CNT_B];
    assign C_serviceNumber = r_svc[CNT_C];
    assign D_serviceNumber = r_svc[CNT_D];
    assign E_serviceNumber = r_svc[CNT_E];

endmodule
